// File: rtl/anton_neopixel_apb_feeder.sv
// Streams host pixel bytes into an APB neopixel peripheral, one byte per word, then commits the frame.
// Optional macro ANTON_NEOPIXEL_FEEDER_READBACK_EN reads each byte back and flags mismatches.
module anton_neopixel_apb_feeder #(
    parameter int          BUFFER_END = 31,
    parameter logic [15:0] CTRL_ADDR  = 16'h8000,
    parameter logic [7:0]  CTRL_DATA  = 8'h01
) (
    input  logic        apbPclk,
    input  logic        apbPreset,
    input  logic        start,
    input  logic [7:0]  pixData,
    input  logic        pixValid,
    input  logic        pixLast,
    output logic        pixReady,
    output logic [15:0] apbPaddr,
    output logic [7:0]  apbPwData,
    output logic        apbPwrite,
    output logic        apbPselx,
    output logic        apbPenable,
    input  logic [7:0]  apbPrData,
    input  logic        apbPready,
    input  logic        apbPslverr,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [13:0] byteCount
);

`ifdef ANTON_NEOPIXEL_FEEDER_READBACK_EN
    typedef enum logic [2:0] {
        IDLE, LOAD, SETUP, ACCESS, CTRL_SETUP, CTRL_ACCESS, RB_SETUP, RB_ACCESS
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, LOAD, SETUP, ACCESS, CTRL_SETUP, CTRL_ACCESS
    } state_t;

    logic unused_prdata;
    assign unused_prdata = ^apbPrData;
`endif

    localparam logic [12:0] LAST_INDEX = 13'(BUFFER_END);

    state_t      state_reg, state_next;
    logic [12:0] index_reg, index_next;
    logic        last_reg, last_next;
    logic [13:0] count_reg, count_next;
    logic        error_reg, error_next;
    logic        done_reg, done_next;
    logic [15:0] paddr_reg, paddr_next;
    logic [7:0]  pwdata_reg, pwdata_next;
    logic        advance;

    always_ff @(posedge apbPclk) begin
        if (apbPreset) begin
            state_reg  <= IDLE;
            index_reg  <= '0;
            last_reg   <= 1'b0;
            count_reg  <= '0;
            error_reg  <= 1'b0;
            done_reg   <= 1'b0;
            paddr_reg  <= '0;
            pwdata_reg <= '0;
        end else begin
            state_reg  <= state_next;
            index_reg  <= index_next;
            last_reg   <= last_next;
            count_reg  <= count_next;
            error_reg  <= error_next;
            done_reg   <= done_next;
            paddr_reg  <= paddr_next;
            pwdata_reg <= pwdata_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        index_next  = index_reg;
        last_next   = last_reg;
        count_next  = count_reg;
        error_next  = error_reg;
        done_next   = 1'b0;
        paddr_next  = paddr_reg;
        pwdata_next = pwdata_reg;
        advance     = 1'b0;
        pixReady    = 1'b0;
        apbPselx    = 1'b0;
        apbPenable  = 1'b0;
        apbPwrite   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                    index_next = '0;
                    count_next = '0;
                    error_next = 1'b0;
                end
            end
            LOAD: begin
                pixReady = 1'b1;
                if (pixValid) begin
                    last_next   = pixLast;
                    pwdata_next = pixData;
                    paddr_next  = {1'b0, index_reg, 2'b00};
                    state_next  = SETUP;
                end
            end
            SETUP: begin
                apbPselx   = 1'b1;
                apbPwrite  = 1'b1;
                state_next = ACCESS;
            end
            ACCESS: begin
                apbPselx   = 1'b1;
                apbPenable = 1'b1;
                apbPwrite  = 1'b1;
                if (apbPready) begin
                    if (apbPslverr) begin
                        error_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        count_next = count_reg + 14'd1;
`ifdef ANTON_NEOPIXEL_FEEDER_READBACK_EN
                        state_next = RB_SETUP;
`else
                        advance    = 1'b1;
`endif
                    end
                end
            end
`ifdef ANTON_NEOPIXEL_FEEDER_READBACK_EN
            RB_SETUP: begin
                apbPselx   = 1'b1;
                state_next = RB_ACCESS;
            end
            RB_ACCESS: begin
                apbPselx   = 1'b1;
                apbPenable = 1'b1;
                if (apbPready) begin
                    // Write data is still held in pwdata_reg, so it doubles as the compare value.
                    if (apbPslverr || (apbPrData != pwdata_reg)) begin
                        error_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
`endif
            CTRL_SETUP: begin
                apbPselx   = 1'b1;
                apbPwrite  = 1'b1;
                state_next = CTRL_ACCESS;
            end
            CTRL_ACCESS: begin
                apbPselx   = 1'b1;
                apbPenable = 1'b1;
                apbPwrite  = 1'b1;
                if (apbPready) begin
                    if (apbPslverr) begin
                        error_next = 1'b1;
                    end else begin
                        done_next = 1'b1;
                    end
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // A frame commits on pixLast or when the buffer is full, whichever comes first.
        if (advance) begin
            if (last_reg || (index_reg == LAST_INDEX)) begin
                paddr_next  = CTRL_ADDR;
                pwdata_next = CTRL_DATA;
                state_next  = CTRL_SETUP;
            end else begin
                index_next = index_reg + 13'd1;
                state_next = LOAD;
            end
        end
    end

    assign apbPaddr  = paddr_reg;
    assign apbPwData = pwdata_reg;
    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign error     = error_reg;
    assign byteCount = count_reg;

endmodule

// File: tb/tb_anton_neopixel_apb_feeder.sv
// Scoreboard bench: stimulus pushes expected APB transfers, a bus monitor pops and compares each completion.
module tb_anton_neopixel_apb_feeder;
    localparam int BE = 3;
`ifdef ANTON_NEOPIXEL_FEEDER_READBACK_EN
    localparam bit READBACK = 1'b1;
    localparam int BYTE_CYC = 5;
`else
    localparam bit READBACK = 1'b0;
    localparam int BYTE_CYC = 3;
`endif

    logic        apbPclk, apbPreset, start, pixValid, pixLast, pixReady;
    logic [7:0]  pixData, apbPwData, apbPrData;
    logic [15:0] apbPaddr;
    logic        apbPwrite, apbPselx, apbPenable, apbPready, apbPslverr;
    logic        busy, done, error;
    logic [13:0] byteCount;

    anton_neopixel_apb_feeder #(.BUFFER_END(BE)) dut (
        .apbPclk(apbPclk), .apbPreset(apbPreset), .start(start),
        .pixData(pixData), .pixValid(pixValid), .pixLast(pixLast), .pixReady(pixReady),
        .apbPaddr(apbPaddr), .apbPwData(apbPwData), .apbPwrite(apbPwrite),
        .apbPselx(apbPselx), .apbPenable(apbPenable), .apbPrData(apbPrData),
        .apbPready(apbPready), .apbPslverr(apbPslverr),
        .busy(busy), .done(done), .error(error), .byteCount(byteCount)
    );

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
        int          len;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          done_cyc = 0;
    int          done_cnt = 0;
    int          acc_run = 0;
    int          stall_n = 0;
    logic [15:0] stall_addr = 16'hFFFF;
    logic        slv_en = 1'b0;
    logic [15:0] slv_addr = 16'hFFFF;
    logic        rb_bad = 1'b0;
    logic [7:0]  mem [0:7];
    logic [7:0]  stim [0:7];

    initial apbPclk = 1'b0;
    always #5 apbPclk = ~apbPclk;
    always @(posedge apbPclk) cyc <= cyc + 1;

    // Completer model: programmable wait states, slverr address, corrupted readback.
    always @(posedge apbPclk)
        acc_run <= (apbPselx && apbPenable && !apbPready) ? acc_run + 1 : 0;
    always @(posedge apbPclk)
        if (!apbPreset && apbPselx && apbPenable && apbPready && apbPwrite && !apbPaddr[15])
            mem[apbPaddr[4:2]] <= apbPwData;
    always_comb apbPready  = !(apbPselx && apbPenable && apbPwrite && apbPaddr == stall_addr && acc_run < stall_n);
    always_comb apbPslverr = slv_en && apbPselx && apbPenable && apbPaddr == slv_addr;
    always_comb apbPrData  = (rb_bad && apbPaddr == 16'd4) ? 8'hFF : mem[apbPaddr[4:2]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Bus monitor: tracks each ACCESS phase for stability and length, then scores the completion.
    logic        in_acc = 1'b0, a_ok = 1'b0, a_wr = 1'b0;
    logic [15:0] a_addr = '0, p_addr = '0;
    logic [7:0]  a_data = '0, p_data = '0;
    logic        p_setup = 1'b0, p_wr = 1'b0;
    int          acc_len = 0;
    always @(negedge apbPclk) begin
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (apbPreset) begin
            in_acc = 1'b0;
        end else if (apbPselx && apbPenable) begin
            if (!in_acc) begin
                in_acc  = 1'b1;
                acc_len = 0;
                a_addr  = apbPaddr;
                a_data  = apbPwData;
                a_wr    = apbPwrite;
                a_ok    = p_setup && p_addr == apbPaddr && p_wr == apbPwrite && (!apbPwrite || p_data == apbPwData);
            end else if (apbPaddr != a_addr || apbPwData != a_data || apbPwrite != a_wr) begin
                a_ok = 1'b0;
            end
            acc_len++;
            if (apbPready) begin
                in_acc = 1'b0;
                $display("txn %s addr=%h wdata=%h rdata=%h cycles=%0d", a_wr ? "WR" : "RD",
                         a_addr, a_data, apbPrData, acc_len);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_txn: got wr=%0b addr=%h data=%h expected none", a_wr, a_addr, a_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (a_wr != e.wr || a_addr != e.addr || (e.wr && a_data != e.data) ||
                        acc_len != e.len || !a_ok) begin
                        errors++;
                        $display("FAIL apb_txn: got wr=%0b addr=%h data=%h len=%0d setup_ok=%0b expected wr=%0b addr=%h data=%h len=%0d",
                                 a_wr, a_addr, a_data, acc_len, a_ok, e.wr, e.addr, e.data, e.len);
                    end
                end
            end
        end
        p_setup = apbPselx && !apbPenable;
        p_addr  = apbPaddr;
        p_data  = apbPwData;
        p_wr    = apbPwrite;
    end

    task automatic push_wr(input int idx, input logic [7:0] d, input int len, input bit rb);
        exp_t e;
        e.wr = 1'b1; e.addr = 16'(idx * 4); e.data = d; e.len = len;
        exp_q.push_back(e);
        if (rb && READBACK) begin
            e.wr = 1'b0; e.len = 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_ctrl();
        exp_t e;
        e.wr = 1'b1; e.addr = 16'h8000; e.data = 8'h01; e.len = 1;
        exp_q.push_back(e);
    endtask

    task automatic do_start();
        @(negedge apbPclk);
        start = 1'b1;
        @(posedge apbPclk);
        #1;
        start = 1'b0;
        start_cyc = cyc;
        check("busy_after_start", 64'(busy), 64'd1);
        check("error_cleared_by_start", 64'(error), 64'd0);
    endtask

    task automatic feed(input int n, input int n_accept, input int last_idx, input bit commit,
                        input int stall_idx, input int err_idx);
        int waited;
        bit seen;
        for (int i = 0; i < n; i++) begin
            @(negedge apbPclk);
            pixData  = stim[i];
            pixValid = 1'b1;
            pixLast  = (i == last_idx);
            if (i < n_accept) begin
                waited = 0;
                while (!pixReady && waited < 100) begin
                    @(negedge apbPclk);
                    waited++;
                end
                check("pix_accept", 64'(pixReady), 64'd1);
                if (pixReady) begin
                    push_wr(i, stim[i], (i == stall_idx) ? stall_n + 1 : 1, i != err_idx);
                    if (commit && (i == last_idx || i == BE)) push_ctrl();
                end
                @(posedge apbPclk);
            end else begin
                seen = 1'b0;
                for (int k = 0; k < 30; k++) begin
                    @(negedge apbPclk);
                    if (pixReady) seen = 1'b1;
                end
                check("no_accept_past_end", 64'(seen), 64'd0);
                break;
            end
        end
        @(negedge apbPclk);
        pixValid = 1'b0;
        pixLast  = 1'b0;
    endtask

    task automatic wait_idle();
        int waited = 0;
        while (busy && waited < 300) begin
            @(negedge apbPclk);
            waited++;
        end
        check("idle_timeout", 64'(busy), 64'd0);
        repeat (2) @(negedge apbPclk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic set_stim(input logic [7:0] base, input logic [7:0] step);
        for (int i = 0; i < 8; i++) stim[i] = base + 8'(i) * step;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int waited;
        start = 1'b0; pixValid = 1'b0; pixLast = 1'b0; pixData = '0;
        apbPreset = 1'b1;
        repeat (3) @(posedge apbPclk);
        #1;
        check("reset_outputs", {19'd0, pixReady, apbPaddr, apbPwData, apbPwrite, apbPselx, apbPenable,
                                busy, done, error, byteCount}, 64'd0);
        @(negedge apbPclk);
        apbPreset = 1'b0;

        // Basic 4-byte frame with pixLast on the 4th byte, no wait states.
        set_stim(8'h11, 8'h11);
        d0 = done_cnt;
        do_start();
        feed(4, 4, 3, 1'b1, -1, -1);
        wait_idle();
        check("basic_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("basic_byte_count", 64'(byteCount), 64'd4);
        check("basic_error", 64'(error), 64'd0);
        check("basic_cycles", 64'(done_cyc - start_cyc), 64'(4 * BYTE_CYC + 2));

        // Six bytes offered without pixLast: only BUFFER_END+1 are taken, then commit.
        set_stim(8'hA0, 8'h01);
        d0 = done_cnt;
        do_start();
        feed(6, 4, -1, 1'b1, -1, -1);
        wait_idle();
        check("full_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("full_byte_count", 64'(byteCount), 64'd4);

        // Five wait states on the byte at address 8.
        set_stim(8'h5A, 8'h13);
        stall_addr = 16'd8;
        stall_n = 5;
        d0 = done_cnt;
        do_start();
        feed(4, 4, 3, 1'b1, 2, -1);
        wait_idle();
        stall_n = 0;
        check("stall_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("stall_error", 64'(error), 64'd0);

        // Slave error on the write to address 4 aborts the frame.
        set_stim(8'h11, 8'h11);
        slv_addr = 16'd4;
        slv_en = 1'b1;
        d0 = done_cnt;
        do_start();
        feed(2, 2, -1, 1'b0, -1, 1);
        wait_idle();
        slv_en = 1'b0;
        check("slverr_error", 64'(error), 64'd1);
        check("slverr_busy", 64'(busy), 64'd0);
        check("slverr_no_done", 64'(done_cnt - d0), 64'd0);
        check("slverr_byte_count", 64'(byteCount), 64'd1);
        set_stim(8'h71, 8'h02);
        d0 = done_cnt;
        do_start();
        feed(2, 2, 1, 1'b1, -1, -1);
        wait_idle();
        check("after_err_done", 64'(done_cnt - d0), 64'd1);
        check("after_err_count", 64'(byteCount), 64'd2);

        // Reset asserted while the byte-1 write is stuck in ACCESS.
        set_stim(8'h33, 8'h10);
        stall_addr = 16'd4;
        stall_n = 1000;
        do_start();
        feed(1, 1, -1, 1'b0, -1, -1);
        @(negedge apbPclk);
        pixData = stim[1];
        pixValid = 1'b1;
        waited = 0;
        while (!(apbPselx && apbPenable && apbPaddr == 16'd4) && waited < 50) begin
            @(negedge apbPclk);
            waited++;
        end
        check("reached_access_byte1", 64'(apbPselx && apbPenable && apbPaddr == 16'd4), 64'd1);
        apbPreset = 1'b1;
        pixValid = 1'b0;
        @(posedge apbPclk);
        #1;
        check("midxfer_reset_outputs", {19'd0, pixReady, apbPaddr, apbPwData, apbPwrite, apbPselx, apbPenable,
                                        busy, done, error, byteCount}, 64'd0);
        @(negedge apbPclk);
        apbPreset = 1'b0;
        stall_n = 0;
        check("reset_queue_drained", 64'(exp_q.size()), 64'd0);
        set_stim(8'hC1, 8'h01);
        d0 = done_cnt;
        do_start();
        feed(2, 2, 1, 1'b1, -1, -1);
        wait_idle();
        check("post_reset_done", 64'(done_cnt - d0), 64'd1);

`ifdef ANTON_NEOPIXEL_FEEDER_READBACK_EN
        // Readback of byte 8'h22 returns 8'hFF.
        set_stim(8'h11, 8'h11);
        rb_bad = 1'b1;
        d0 = done_cnt;
        do_start();
        feed(2, 2, -1, 1'b0, -1, -1);
        wait_idle();
        rb_bad = 1'b0;
        check("rb_error", 64'(error), 64'd1);
        check("rb_no_done", 64'(done_cnt - d0), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/anton_neopixel_apb_feeder.md
ANTON_NEOPIXEL_APB_FEEDER -- requirements
Module: anton_neopixel_apb_feeder

Interface
REQ-001 Parameter BUFFER_END, default 31: index of last pixel byte slot; frame holds BUFFER_END+1 bytes, maximum 8191.
REQ-002 Parameter CTRL_ADDR, default 16'h8000: APB address of the neopixel control register (bit 15 set).
REQ-003 Parameter CTRL_DATA, default 8'h01: value written to CTRL_ADDR to commit a frame.
REQ-004 apbPclk  in  1  single clock; every flop on its rising edge.
REQ-005 apbPreset  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  one-cycle request to begin a frame upload.
REQ-007 pixData  in  8  pixel byte from the host stream.
REQ-008 pixValid  in  1  pixData valid.
REQ-009 pixLast  in  1  qualifies pixData as the final byte of the frame.
REQ-010 pixReady  out  1  feeder accepts pixData this cycle.
REQ-011 apbPaddr  out  16  APB address; pixel byte n at n<<2.
REQ-012 apbPwData  out  8  APB write data.
REQ-013 apbPwrite / apbPselx / apbPenable  out  1 each  APB master controls.
REQ-014 apbPrData  in  8  APB read data.
REQ-015 apbPready / apbPslverr  in  1 each  APB completer status.
REQ-016 busy  out  1  upload in progress.
REQ-017 done  out  1  one-cycle pulse on successful frame commit.
REQ-018 error  out  1  sticky; set on slverr or readback mismatch, cleared by next accepted start.
REQ-019 byteCount  out  14  bytes written in the current or last frame.

Function
REQ-020 States: IDLE, LOAD, SETUP, ACCESS, RB_SETUP, RB_ACCESS, CTRL_SETUP, CTRL_ACCESS.
REQ-021 IDLE: start=1 -> LOAD; index, byteCount, and error cleared; busy=1 from the next cycle.
REQ-022 start while not in IDLE is ignored.
REQ-023 LOAD: pixReady=1; on pixValid&pixReady, byte and pixLast are captured -> SETUP; pixReady=0 in all other states.
REQ-024 SETUP (one cycle): apbPselx=1, apbPenable=0, apbPwrite=1, apbPaddr={index,2'b00} (index zero-extended to 14 bits), apbPwData=captured byte.
REQ-025 ACCESS: same address, data and write, apbPenable=1; held while apbPready=0, with no limit on wait states.
REQ-026 Completion in ACCESS (apbPready=1) with apbPslverr=1 -> error=1 and return to IDLE; no control write; done stays 0.
REQ-027 Completion in ACCESS with apbPslverr=0 -> byteCount+1; if the captured pixLast=1 or index==BUFFER_END -> CTRL_SETUP, else index+1 -> LOAD.
REQ-028 Bytes beyond BUFFER_END are never accepted; a frame reaching BUFFER_END without pixLast still commits.
REQ-029 CTRL_SETUP/CTRL_ACCESS: write CTRL_DATA to CTRL_ADDR with the same two-phase protocol; completion without slverr -> done=1 for one cycle and return to IDLE; with slverr -> error=1 and return to IDLE.
REQ-030 apbPselx, apbPenable, and apbPwrite are 0 in IDLE and LOAD; apbPaddr and apbPwData hold their last values there.
REQ-031 Minimum cost is 3 cycles per byte with no wait states (LOAD, SETUP, ACCESS) when pixValid is continuously 1.
REQ-032 busy=1 in every state except IDLE.

Reset
REQ-033 apbPreset=1 at a clock edge forces IDLE regardless of state, including mid-transfer.
REQ-034 Outputs 0 after reset: pixReady, apbPaddr, apbPwData, apbPwrite, apbPselx, apbPenable, busy, done, error, byteCount; internal index and capture registers are also 0.
REQ-035 An APB transfer aborted by reset is not resumed.

Configuration
REQ-036 Macro ANTON_NEOPIXEL_FEEDER_READBACK_EN defined: a successful ACCESS -> RB_SETUP/RB_ACCESS, a read (apbPwrite=0) of the same address.
REQ-037 With the macro, a completed read with apbPrData != written byte, or with slverr -> error=1 and return to IDLE; a match continues as in REQ-027.
REQ-038 With the macro, the minimum cost becomes 5 cycles per byte.
REQ-039 Without the macro, the RB states and their logic are absent, and apbPrData is unused.

Verification
REQ-040 Reset, start, then 4 bytes 8'h11..8'h44 with pixLast on 8'h44, apbPready=1 -> writes to addresses 0,4,8,12, then 8'h01 to 16'h8000; done pulses once; byteCount=4; error=0.
REQ-041 BUFFER_END=3, 6 bytes offered with no pixLast -> only 4 accepted, then the control write follows, and pixReady stays 0 after the 4th byte.
REQ-042 apbPready held 0 for 5 cycles on byte 2 -> apbPaddr=8, apbPwData, and apbPenable=1 stable for all 6 ACCESS cycles; the frame completes normally.
REQ-043 apbPslverr=1 on the byte at address 4 -> error=1, no write to 16'h8000, done=0, busy=0; the next start clears error.
REQ-044 apbPreset asserted during ACCESS of byte 1 -> the next cycle shows all outputs 0 and state IDLE; a new start uploads from address 0.
REQ-045 With ANTON_NEOPIXEL_FEEDER_READBACK_EN defined, the completer returns 8'hFF on the readback of written byte 8'h22 -> error=1, no control write.
